mopshub_can_rec_arbiter: RTL

- Parametrised successor to the fixed 32-bus CAN receive path of the MOPSHUB top level.
- Collects "frame received" requests from N_BUS CAN bus controllers and picks one by round-robin among the active buses.
- Latches the selected 76-bit frame and presents it to the uplink (elink) side with a valid/ready handshake.
- Adds what the 32-bus top lacks: a runtime bus mask, a runtime-limited active bus count, and timeout-based frame drop when the uplink stalls.

---
 rtl/mopshub_can_rec_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mopshub_can_rec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mopshub_can_rec_arbiter
// Brief    : Round-robin arbiter for CAN "frame received" requests with
//            masking, runtime bus limit, uplink valid/ready and stall timeout.
//            Optional drop statistics ports: define MOPSHUB_ARB_DROP_STATS_EN.
// Revision : 1.0
// ============================================================================
module mopshub_can_rec_arbiter #(
  parameter int N_BUS       = 32,
  parameter int DATA_W      = 76,
  parameter int SEL_W       = 5,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        n_buses,
  input  logic [N_BUS-1:0]        bus_mask,
  input  logic [N_BUS-1:0]        irq_can_rec,
  input  logic [N_BUS*DATA_W-1:0] can_rec_data,
  output logic [N_BUS-1:0]        can_rec_ack,
  output logic [SEL_W-1:0]        can_rec_select,
  output logic [DATA_W-1:0]       data_rec_uplink,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic                    rec_timeout,
  output logic                    busy
`ifdef MOPSHUB_ARB_DROP_STATS_EN
  ,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [SEL_W-1:0]        last_drop_bus
`endif
);

  localparam int               c_tmo_w   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [SEL_W-1:0] c_n_max   = SEL_W'(N_BUS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t               state_q;
  logic [N_BUS-1:0]     ack_q;
  logic [SEL_W-1:0]     sel_q;
  logic [DATA_W-1:0]    data_q;
  logic                 valid_q;
  logic                 timeout_q;
  logic                 busy_q;
  logic [c_tmo_w-1:0]   tmo_cnt_q;
  // Index where the next search begins (last grant + 1); may exceed n_buses.
  logic [SEL_W:0]       start_q;
`ifdef MOPSHUB_ARB_DROP_STATS_EN
  logic [CNT_W-1:0]     drop_cnt_q;
  logic [SEL_W-1:0]     last_drop_q;
`endif

  logic [SEL_W-1:0]     w_n_cl;
  logic [N_BUS-1:0]     w_elig;
  logic [DATA_W-1:0]    w_frames [N_BUS];
  logic                 w_found;
  logic [SEL_W-1:0]     w_gnt;
  int                   w_base;
  int                   w_idx;

  always_comb begin
    w_n_cl = n_buses;
    if (int'(n_buses) > N_BUS - 1) w_n_cl = c_n_max;
  end

  for (genvar gi = 0; gi < N_BUS; gi++) begin : g_bus
    assign w_elig[gi]   = irq_can_rec[gi] & ~bus_mask[gi] & (gi <= int'(w_n_cl));
    assign w_frames[gi] = can_rec_data[gi*DATA_W +: DATA_W];
  end

  // A stale start index beyond the active range restarts the search at bus 0.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_base  = (int'(start_q) > int'(w_n_cl)) ? 0 : int'(start_q);
    w_idx   = 0;
    for (int k = 0; k < N_BUS; k++) begin
      if (!w_found && (k <= int'(w_n_cl))) begin
        w_idx = w_base + k;
        if (w_idx > int'(w_n_cl)) w_idx = w_idx - int'(w_n_cl) - 1;
        if (w_elig[w_idx[SEL_W-1:0]]) begin
          w_found = 1'b1;
          w_gnt   = w_idx[SEL_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ack_q       <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      tmo_cnt_q   <= '0;
      start_q     <= '0;
`ifdef MOPSHUB_ARB_DROP_STATS_EN
      drop_cnt_q  <= '0;
      last_drop_q <= '0;
`endif
    end else begin
      ack_q     <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            state_q <= S_GRANT;
            sel_q   <= w_gnt;
            busy_q  <= 1'b1;
          end
        end
        // Frame is captured here regardless of whether the request is still up.
        S_GRANT: begin
          data_q       <= w_frames[sel_q];
          ack_q[sel_q] <= 1'b1;
          valid_q      <= 1'b1;
          tmo_cnt_q    <= '0;
          start_q      <= {1'b0, sel_q} + 1'b1;
          state_q      <= S_SEND;
        end
        S_SEND: begin
          if (rec_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (TIMEOUT_CYC != 0) begin
            if (tmo_cnt_q == c_tmo_last) begin
              valid_q   <= 1'b0;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
`ifdef MOPSHUB_ARB_DROP_STATS_EN
              if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;
              last_drop_q <= sel_q;
`endif
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign can_rec_ack     = ack_q;
  assign can_rec_select  = sel_q;
  assign data_rec_uplink = data_q;
  assign rec_valid       = valid_q;
  assign rec_timeout     = timeout_q;
  assign busy            = busy_q;
`ifdef MOPSHUB_ARB_DROP_STATS_EN
  assign drop_cnt        = drop_cnt_q;
  assign last_drop_bus   = last_drop_q;
`endif

endmodule
`default_nettype wire
